// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the memory-port arbiter slice:
//   - XLEN         : data/address width
//   - ARB_*        : arbiter FSM state encodings
//   - F3_WORD      : size code used for I-cache refills (full word)
//   - prio_t       : priority pointer (which side wins a tie)
//   - mem_cmd_t    : bundle of the muxed memory command fields
package mem_port_arbiter_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_GNT_IC = 2'd1;
  localparam logic [1:0] ARB_GNT_DM = 2'd2;

  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic {
    PRIO_IC = 1'b0,
    PRIO_DM = 1'b1
  } prio_t;

  typedef struct packed {
    logic            wen;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wd;
    logic [2:0]      f3;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three buses around the arbiter: I-cache refill side,
//   data-memory side and the shared external memory port.
//   Modports:
//     slave  : the arbiter (consumes requests/memory response, drives the rest)
//     master : the environment (requesters + memory) on the other side
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  // I-cache refill side
  logic            i_IC_Req;
  logic [XLEN-1:0] i_IC_Addr;
  logic            o_IC_Ready;
  logic [XLEN-1:0] o_IC_Data;

  // data-memory side
  logic            i_DM_Req;
  logic            i_DM_Wen;
  logic [XLEN-1:0] i_DM_Addr;
  logic [XLEN-1:0] i_DM_Wd;
  logic [2:0]      i_DM_f3;
  logic            o_DM_Ready;
  logic [XLEN-1:0] o_DM_Data;
  logic            o_DM_Stall;

  // external memory port
  logic            o_MEM_Req;
  logic            o_MEM_Wen;
  logic [XLEN-1:0] o_MEM_Addr;
  logic [XLEN-1:0] o_MEM_Wd;
  logic [2:0]      o_MEM_f3;
  logic            i_MEM_Ready;
  logic [XLEN-1:0] i_MEM_ReadData;

  // watchdog status
  logic            o_Err;
  logic            o_ErrSrc;

  modport slave (
    input  i_IC_Req, i_IC_Addr,
    input  i_DM_Req, i_DM_Wen, i_DM_Addr, i_DM_Wd, i_DM_f3,
    input  i_MEM_Ready, i_MEM_ReadData,
    output o_IC_Ready, o_IC_Data,
    output o_DM_Ready, o_DM_Data, o_DM_Stall,
    output o_MEM_Req, o_MEM_Wen, o_MEM_Addr, o_MEM_Wd, o_MEM_f3,
    output o_Err, o_ErrSrc
  );

  modport master (
    output i_IC_Req, i_IC_Addr,
    output i_DM_Req, i_DM_Wen, i_DM_Addr, i_DM_Wd, i_DM_f3,
    output i_MEM_Ready, i_MEM_ReadData,
    input  o_IC_Ready, o_IC_Data,
    input  o_DM_Ready, o_DM_Data, o_DM_Stall,
    input  o_MEM_Req, o_MEM_Wen, o_MEM_Addr, o_MEM_Wd, o_MEM_f3,
    input  o_Err, o_ErrSrc
  );

endinterface

// File: rtl/arb_watchdog.sv
// arb_watchdog
//   Counts grant cycles and flags the cycle in which the grant has lasted
//   TIMEOUT cycles.
//   Ports:
//     i_clk, i_rst : clock, synchronous active-high reset
//     clear        : return the count to zero (transaction ended)
//     enable       : a grant is active this cycle; count it
//     expire       : this is the TIMEOUT-th grant cycle (combinational)
module arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (enable) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // The count starts at 0 in the first grant cycle, so TIMEOUT-1 marks
  // the TIMEOUT-th cycle of the grant.
  assign expire = enable && (cnt_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between the I-cache refill side and the
//   data-memory side. One grant at a time, held until the memory answers or
//   the watchdog gives up; the priority pointer alternates after every
//   finished or aborted grant.
//   Ports:
//     i_clk, i_rst : clock, synchronous active-high reset
//     bus          : mem_port_arbiter_if.slave (requesters, memory port,
//                    error status)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mem_port_arbiter_if.slave   bus
);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  prio_t      prio_reg;
  prio_t      prio_next;
  logic       err_src_reg;

  logic       in_ic;
  logic       in_dm;
  logic       granted;
  logic       done;
  logic       expire;
  logic       abort;
  mem_cmd_t   cmd;

  assign in_ic   = (state_reg == ARB_GNT_IC);
  assign in_dm   = (state_reg == ARB_GNT_DM);
  assign granted = in_ic | in_dm;

  // A reset cycle never reports completion or abort, even if the memory
  // happens to answer in it.
  assign done  = granted & bus.i_MEM_Ready & ~i_rst;
  // Completion wins over a watchdog expiry in the same cycle.
  assign abort = expire & ~bus.i_MEM_Ready & ~i_rst;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (done | abort),
    .enable (granted),
    .expire (expire)
  );

  always_comb begin
    state_next = state_reg;
    prio_next  = prio_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (bus.i_IC_Req && bus.i_DM_Req) begin
          state_next = (prio_reg == PRIO_DM) ? ARB_GNT_DM : ARB_GNT_IC;
        end else if (bus.i_IC_Req) begin
          state_next = ARB_GNT_IC;
        end else if (bus.i_DM_Req) begin
          state_next = ARB_GNT_DM;
        end
      end
      ARB_GNT_IC, ARB_GNT_DM: begin
        // Always pass through IDLE between grants; the side just served
        // loses the next tie.
        if (done || abort) begin
          state_next = ARB_IDLE;
          prio_next  = in_ic ? PRIO_DM : PRIO_IC;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ARB_IDLE;
      prio_reg    <= PRIO_IC;
      err_src_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
      if (abort) begin
        err_src_reg <= in_dm;
      end
    end
  end

  // Memory command comes straight from the granted requester's inputs.
  always_comb begin
    cmd = '0;
    if (in_ic) begin
      cmd.addr = bus.i_IC_Addr;
      cmd.f3   = F3_WORD;
    end else if (in_dm) begin
      cmd.wen  = bus.i_DM_Wen;
      cmd.addr = bus.i_DM_Addr;
      cmd.wd   = bus.i_DM_Wd;
      cmd.f3   = bus.i_DM_f3;
    end
  end

  assign bus.o_MEM_Req  = granted;
  assign bus.o_MEM_Wen  = cmd.wen;
  assign bus.o_MEM_Addr = cmd.addr;
  assign bus.o_MEM_Wd   = cmd.wd;
  assign bus.o_MEM_f3   = cmd.f3;

  assign bus.o_IC_Ready = done & in_ic;
  assign bus.o_IC_Data  = (done & in_ic) ? bus.i_MEM_ReadData : '0;
  assign bus.o_DM_Ready = done & in_dm;
  assign bus.o_DM_Data  = (done & in_dm) ? bus.i_MEM_ReadData : '0;
  assign bus.o_DM_Stall = bus.i_DM_Req & ~bus.o_DM_Ready;

  assign bus.o_Err    = abort;
  assign bus.o_ErrSrc = err_src_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (TIMEOUT=4). Expected completions
//   and aborts are queued when a request is driven and checked by a
//   negedge monitor as the DUT produces Ready/Err pulses.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .TIMEOUT (4),
    .CNT_W   (16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ev is {err, dm_ready, ic_ready}; data is {ic_data, dm_data}
  typedef struct {
    logic [2:0]  ev;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  logic [2:0] mon_ev;
  exp_t       mon_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] ev, input logic [31:0] ic_d, input logic [31:0] dm_d);
    exp_t e;
    e.ev   = ev;
    e.data = {ic_d, dm_d};
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Scoreboard monitor: one line per Ready/Err event.
  always @(negedge clk) begin
    if (!rst) begin
      mon_ev = {bus.o_Err, bus.o_DM_Ready, bus.o_IC_Ready};
      if (mon_ev != 3'b000) begin
        chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_event", 64'(mon_ev), 64'(mon_e.ev));
          chk("sb_data", {bus.o_IC_Data, bus.o_DM_Data}, mon_e.data);
          $display("txn t=%0t ev=%b ic_data=%h dm_data=%h", $time, mon_ev,
                   bus.o_IC_Data, bus.o_DM_Data);
        end
      end else begin
        chk("data_zero_when_not_ready", {bus.o_IC_Data, bus.o_DM_Data}, 64'd0);
      end
    end
  end

  initial begin
    bus.i_IC_Req       = 1'b0;
    bus.i_IC_Addr      = '0;
    bus.i_DM_Req       = 1'b0;
    bus.i_DM_Wen       = 1'b0;
    bus.i_DM_Addr      = '0;
    bus.i_DM_Wd        = '0;
    bus.i_DM_f3        = '0;
    bus.i_MEM_Ready    = 1'b0;
    bus.i_MEM_ReadData = '0;

    // ---- reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    chk("rst_mem_req",  64'(bus.o_MEM_Req),  64'd0);
    chk("rst_mem_addr", 64'(bus.o_MEM_Addr), 64'd0);
    chk("rst_mem_wen",  64'(bus.o_MEM_Wen),  64'd0);
    chk("rst_mem_wd",   64'(bus.o_MEM_Wd),   64'd0);
    chk("rst_mem_f3",   64'(bus.o_MEM_f3),   64'd0);
    chk("rst_ic_ready", 64'(bus.o_IC_Ready), 64'd0);
    chk("rst_dm_ready", 64'(bus.o_DM_Ready), 64'd0);
    chk("rst_err",      64'(bus.o_Err),      64'd0);
    chk("rst_errsrc",   64'(bus.o_ErrSrc),   64'd0);
    chk("rst_stall",    64'(bus.o_DM_Stall), 64'd0);

    // ---- single IC read, memory answers in the 4th grant cycle
    next_cycle();
    bus.i_IC_Req  = 1'b1;
    bus.i_IC_Addr = 32'h100;
    push(3'b001, 32'hDEADBEEF, 32'h0);
    settle();
    chk("ic_arb_mem_req", 64'(bus.o_MEM_Req), 64'd0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 3) begin
        bus.i_MEM_Ready    = 1'b1;
        bus.i_MEM_ReadData = 32'hDEADBEEF;
      end
      settle();
      chk("ic_mem_req",  64'(bus.o_MEM_Req),  64'd1);
      chk("ic_mem_addr", 64'(bus.o_MEM_Addr), 64'h100);
      chk("ic_mem_f3",   64'(bus.o_MEM_f3),   64'd2);
      chk("ic_mem_wen",  64'(bus.o_MEM_Wen),  64'd0);
      chk("ic_mem_wd",   64'(bus.o_MEM_Wd),   64'd0);
      chk("ic_stall",    64'(bus.o_DM_Stall), 64'd0);
      chk("ic_ready",    64'(bus.o_IC_Ready), 64'(i == 3));
      chk("ic_no_err",   64'(bus.o_Err),      64'd0);
    end
    next_cycle();
    bus.i_IC_Req       = 1'b0;
    bus.i_MEM_Ready    = 1'b0;
    bus.i_MEM_ReadData = '0;
    settle();
    chk("ic_done_idle", 64'(bus.o_MEM_Req), 64'd0);

    // ---- simultaneous requests from reset: IC, DM, IC alternation
    next_cycle();
    rst = 1'b1;
    settle();
    next_cycle();
    rst           = 1'b0;
    bus.i_IC_Req  = 1'b1;
    bus.i_IC_Addr = 32'h200;
    bus.i_DM_Req  = 1'b1;
    bus.i_DM_Wen  = 1'b0;
    bus.i_DM_Addr = 32'h1004;
    bus.i_DM_f3   = 3'b010;
    push(3'b001, 32'hA1, 32'h0);
    push(3'b010, 32'h0, 32'hB2);
    push(3'b001, 32'hC3, 32'h0);
    settle();
    chk("both_arb_stall",   64'(bus.o_DM_Stall), 64'd1);
    chk("both_arb_mem_req", 64'(bus.o_MEM_Req),  64'd0);
    next_cycle();
    settle();
    chk("both_first_ic_addr", 64'(bus.o_MEM_Addr), 64'h200);
    chk("both_first_stall",   64'(bus.o_DM_Stall), 64'd1);
    next_cycle();
    bus.i_MEM_Ready    = 1'b1;
    bus.i_MEM_ReadData = 32'hA1;
    settle();
    chk("both_ic_done_stall", 64'(bus.o_DM_Stall), 64'd1);
    next_cycle();
    bus.i_MEM_Ready    = 1'b0;
    bus.i_MEM_ReadData = '0;
    settle();
    chk("both_gap_mem_req", 64'(bus.o_MEM_Req),  64'd0);
    chk("both_gap_stall",   64'(bus.o_DM_Stall), 64'd1);
    next_cycle();
    settle();
    chk("both_dm_addr",  64'(bus.o_MEM_Addr), 64'h1004);
    chk("both_dm_f3",    64'(bus.o_MEM_f3),   64'd2);
    chk("both_dm_stall", 64'(bus.o_DM_Stall), 64'd1);
    next_cycle();
    bus.i_MEM_Ready    = 1'b1;
    bus.i_MEM_ReadData = 32'hB2;
    settle();
    chk("both_dm_ready_stall", 64'(bus.o_DM_Stall), 64'd0);
    next_cycle();
    bus.i_MEM_Ready    = 1'b0;
    bus.i_MEM_ReadData = '0;
    bus.i_DM_Req       = 1'b0;
    settle();
    chk("both_gap2_mem_req", 64'(bus.o_MEM_Req), 64'd0);
    next_cycle();
    settle();
    chk("both_third_ic_addr", 64'(bus.o_MEM_Addr), 64'h200);
    next_cycle();
    bus.i_MEM_Ready    = 1'b1;
    bus.i_MEM_ReadData = 32'hC3;
    settle();
    next_cycle();
    bus.i_MEM_Ready    = 1'b0;
    bus.i_MEM_ReadData = '0;
    bus.i_IC_Req       = 1'b0;
    settle();
    chk("both_end_idle", 64'(bus.o_MEM_Req), 64'd0);

    // ---- DM store completing in the first grant cycle
    next_cycle();
    bus.i_DM_Req  = 1'b1;
    bus.i_DM_Wen  = 1'b1;
    bus.i_DM_Addr = 32'h2000;
    bus.i_DM_Wd   = 32'h12345678;
    bus.i_DM_f3   = 3'b000;
    push(3'b010, 32'h0, 32'h0);
    settle();
    chk("st_arb_stall", 64'(bus.o_DM_Stall), 64'd1);
    next_cycle();
    bus.i_MEM_Ready    = 1'b1;
    bus.i_MEM_ReadData = '0;
    settle();
    chk("st_mem_req",  64'(bus.o_MEM_Req),  64'd1);
    chk("st_mem_wen",  64'(bus.o_MEM_Wen),  64'd1);
    chk("st_mem_addr", 64'(bus.o_MEM_Addr), 64'h2000);
    chk("st_mem_wd",   64'(bus.o_MEM_Wd),   64'h12345678);
    chk("st_mem_f3",   64'(bus.o_MEM_f3),   64'd0);
    next_cycle();
    bus.i_MEM_Ready = 1'b0;
    bus.i_DM_Req    = 1'b0;
    bus.i_DM_Wen    = 1'b0;
    bus.i_DM_Wd     = '0;
    settle();
    chk("st_idle", 64'(bus.o_MEM_Req), 64'd0);

    // ---- watchdog abort on a DM load
    next_cycle();
    bus.i_DM_Req  = 1'b1;
    bus.i_DM_Addr = 32'h3000;
    bus.i_DM_f3   = 3'b010;
    push(3'b100, 32'h0, 32'h0);
    settle();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      settle();
      chk("wd_mem_req",  64'(bus.o_MEM_Req),  64'd1);
      chk("wd_err",      64'(bus.o_Err),      64'(i == 3));
      chk("wd_no_ready", 64'(bus.o_DM_Ready), 64'd0);
    end
    next_cycle();
    bus.i_DM_Req = 1'b0;
    settle();
    chk("wd_after_mem_req", 64'(bus.o_MEM_Req), 64'd0);
    chk("wd_after_errsrc",  64'(bus.o_ErrSrc),  64'd1);
    chk("wd_after_err",     64'(bus.o_Err),     64'd0);

    // ---- same again, but memory answers in the expiry cycle
    next_cycle();
    bus.i_DM_Req = 1'b1;
    push(3'b010, 32'h0, 32'h55AA);
    settle();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 3) begin
        bus.i_MEM_Ready    = 1'b1;
        bus.i_MEM_ReadData = 32'h55AA;
      end
      settle();
      chk("wd2_no_err",   64'(bus.o_Err),      64'd0);
      chk("wd2_errsrc",   64'(bus.o_ErrSrc),   64'd1);
      chk("wd2_dm_ready", 64'(bus.o_DM_Ready), 64'(i == 3));
    end
    next_cycle();
    bus.i_MEM_Ready    = 1'b0;
    bus.i_MEM_ReadData = '0;
    bus.i_DM_Req       = 1'b0;
    settle();
    chk("wd2_idle", 64'(bus.o_MEM_Req), 64'd0);

    // ---- IC read so the priority pointer ends on DM
    next_cycle();
    bus.i_IC_Req  = 1'b1;
    bus.i_IC_Addr = 32'h180;
    push(3'b001, 32'h77, 32'h0);
    settle();
    next_cycle();
    bus.i_MEM_Ready    = 1'b1;
    bus.i_MEM_ReadData = 32'h77;
    settle();
    chk("pre_ic_addr", 64'(bus.o_MEM_Addr), 64'h180);
    next_cycle();
    bus.i_MEM_Ready    = 1'b0;
    bus.i_MEM_ReadData = '0;
    bus.i_IC_Req       = 1'b0;
    settle();

    // ---- reset in the second IC grant cycle
    next_cycle();
    bus.i_IC_Req  = 1'b1;
    bus.i_IC_Addr = 32'h400;
    settle();
    next_cycle();
    settle();
    chk("rmid_grant", 64'(bus.o_MEM_Req), 64'd1);
    next_cycle();
    rst                = 1'b1;
    bus.i_MEM_Ready    = 1'b1;
    bus.i_MEM_ReadData = 32'hBAD;
    settle();
    chk("rmid_no_ic_ready", 64'(bus.o_IC_Ready), 64'd0);
    chk("rmid_no_ic_data",  64'(bus.o_IC_Data),  64'd0);
    next_cycle();
    rst                = 1'b0;
    bus.i_MEM_Ready    = 1'b0;
    bus.i_MEM_ReadData = '0;
    bus.i_DM_Req       = 1'b1;
    bus.i_DM_Wen       = 1'b0;
    bus.i_DM_Addr      = 32'h5000;
    bus.i_DM_f3        = 3'b010;
    push(3'b001, 32'h99, 32'h0);
    settle();
    chk("rmid_dropped", 64'(bus.o_MEM_Req),  64'd0);
    chk("rmid_stall",   64'(bus.o_DM_Stall), 64'd1);
    next_cycle();
    bus.i_MEM_Ready    = 1'b1;
    bus.i_MEM_ReadData = 32'h99;
    settle();
    chk("rmid_prio_ic_addr", 64'(bus.o_MEM_Addr), 64'h400);
    chk("rmid_ic_ready",     64'(bus.o_IC_Ready), 64'd1);
    next_cycle();
    bus.i_MEM_Ready    = 1'b0;
    bus.i_MEM_ReadData = '0;
    bus.i_IC_Req       = 1'b0;
    push(3'b010, 32'h0, 32'h66);
    settle();
    next_cycle();
    bus.i_MEM_Ready    = 1'b1;
    bus.i_MEM_ReadData = 32'h66;
    settle();
    chk("rmid_dm_addr", 64'(bus.o_MEM_Addr), 64'h5000);
    next_cycle();
    bus.i_MEM_Ready    = 1'b0;
    bus.i_MEM_ReadData = '0;
    bus.i_DM_Req       = 1'b0;
    settle();
    next_cycle();
    settle();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
